exe_stage_module: RTL

EXE_STAGE_MODULE -- requirements
Module: exe_stage_module

---
 rtl/exe_stage_module_pkg.sv | 59 +++++
 rtl/exe_stage_module_if.sv | 14 +
 rtl/exe_stage_module_alu.sv | 55 +++++
 rtl/exe_stage_module.sv | 120 ++++++++++++
 4 files changed

// File: rtl/exe_stage_module_pkg.sv
// rtl/exe_stage_module_pkg.sv - shared widths, ALU command codes and helpers for the execute stage
package exe_stage_module_pkg;

    localparam int WORD_W   = 32;
    localparam int CMD_W    = 4;
    localparam int REG_W    = 4;
    localparam int SHIFT_W  = 12;
    localparam int IMM24_W  = 24;
    localparam int FLAG_W   = 4;
    localparam int IMM8_W   = 8;
    localparam int SHAMT_W  = 5;
    localparam int SEL_W    = 2;
    localparam int BR_SHIFT = 2;

    // Shifter-field bit positions
    localparam int SH_IMM_BIT  = 4;
    localparam int SH_TYPE_LSB = 5;
    localparam int SH_AMT_LSB  = 7;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] EXE_MVN = 4'b1001;
    localparam logic [CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] EXE_EOR = 4'b1000;

    localparam logic [SEL_W-1:0] FWD_MEM = 2'b01;
    localparam logic [SEL_W-1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic [REG_W-1:0]  dest;
        logic [WORD_W-1:0] alu_result;
        logic [WORD_W-1:0] store_val;
    } exe_mem_t;

    function automatic logic [WORD_W-1:0] ror_word(input logic [WORD_W-1:0] v,
                                                   input logic [SHAMT_W-1:0] amt);
        logic [2*WORD_W-1:0] dbl;
        dbl = {v, v} >> amt;
        return dbl[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/exe_stage_module_if.sv
// rtl/exe_stage_module_if.sv - operand/result bus between the execute stage and its ALU
interface exe_stage_module_if;
    import exe_stage_module_pkg::*;

    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic [CMD_W-1:0]  cmd;
    logic [FLAG_W-1:0] flags_in;
    logic [WORD_W-1:0] result;
    logic [FLAG_W-1:0] flags_out;

    modport master (output op_a, op_b, cmd, flags_in, input result, flags_out);
    modport slave  (input op_a, op_b, cmd, flags_in, output result, flags_out);
endinterface

// File: rtl/exe_stage_module_alu.sv
// rtl/exe_stage_module_alu.sv - 32-bit ALU with NZCV flag generation
module exe_alu
    import exe_stage_module_pkg::*;
(
    exe_stage_module_if.slave alu_if
);

    logic [WORD_W:0]   sum;
    logic [WORD_W-1:0] res;
    logic [FLAG_W-1:0] flags;
    logic              valid;
    logic              is_add;
    logic              is_sub;
    logic              c_in;

    assign c_in   = alu_if.flags_in[FLAG_C];
    assign is_add = (alu_if.cmd == EXE_ADD) || (alu_if.cmd == EXE_ADC);
    assign is_sub = (alu_if.cmd == EXE_SUB) || (alu_if.cmd == EXE_SBC);

    always_comb begin
        sum   = '0;
        res   = '0;
        flags = alu_if.flags_in;
        valid = 1'b1;
        case (alu_if.cmd)
            EXE_MOV: res = alu_if.op_b;
            EXE_MVN: res = ~alu_if.op_b;
            EXE_ADD: sum = {1'b0, alu_if.op_a} + {1'b0, alu_if.op_b};
            EXE_ADC: sum = {1'b0, alu_if.op_a} + {1'b0, alu_if.op_b} + {{WORD_W{1'b0}}, c_in};
            EXE_SUB: sum = {1'b0, alu_if.op_a} - {1'b0, alu_if.op_b};
            EXE_SBC: sum = {1'b0, alu_if.op_a} - {1'b0, alu_if.op_b} - {{WORD_W{1'b0}}, ~c_in};
            EXE_AND: res = alu_if.op_a & alu_if.op_b;
            EXE_ORR: res = alu_if.op_a | alu_if.op_b;
            EXE_EOR: res = alu_if.op_a ^ alu_if.op_b;
            default: valid = 1'b0;
        endcase

        // Subtraction reports carry as NOT borrow; bit WORD_W of the difference is the borrow
        if (is_add || is_sub) begin
            res           = sum[WORD_W-1:0];
            flags[FLAG_C] = is_add ? sum[WORD_W] : ~sum[WORD_W];
            flags[FLAG_V] = (is_add ? (alu_if.op_a[WORD_W-1] == alu_if.op_b[WORD_W-1])
                                    : (alu_if.op_a[WORD_W-1] != alu_if.op_b[WORD_W-1]))
                            && (res[WORD_W-1] != alu_if.op_a[WORD_W-1]);
        end
        if (valid) begin
            flags[FLAG_N] = res[WORD_W-1];
            flags[FLAG_Z] = (res == '0);
        end
    end

    assign alu_if.result    = res;
    assign alu_if.flags_out = flags;

endmodule

// File: rtl/exe_stage_module.sv
// rtl/exe_stage_module.sv - execute stage: forwarding, Val2 shifter, ALU, branch target, EXE/MEM register
module exe_stage_module
    import exe_stage_module_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_en_in,
    input  logic               mem_r_en_in,
    input  logic               mem_w_en_in,
    input  logic               b_in,
    input  logic               s_in,
    input  logic [CMD_W-1:0]   exec_cmd_in,
    input  logic [WORD_W-1:0]  pc_in,
    input  logic [WORD_W-1:0]  val_r_n_in,
    input  logic [WORD_W-1:0]  val_r_m_in,
    input  logic               imm_in,
    input  logic [SHIFT_W-1:0] shift_operand_in,
    input  logic [IMM24_W-1:0] signed_imm_24_in,
    input  logic [REG_W-1:0]   dest_in,
    input  logic [SEL_W-1:0]   sel_src_1,
    input  logic [SEL_W-1:0]   sel_src_2,
    input  logic [WORD_W-1:0]  mem_fwd_val,
    input  logic [WORD_W-1:0]  wb_fwd_val,
    input  logic               mem_freeze,
    output logic               wb_en_out,
    output logic               mem_r_en_out,
    output logic               mem_w_en_out,
    output logic [WORD_W-1:0]  alu_result,
    output logic [WORD_W-1:0]  store_val,
    output logic [REG_W-1:0]   dest_out,
    output logic               branch_taken,
    output logic [WORD_W-1:0]  branch_addr,
    output logic [FLAG_W-1:0]  status_reg
);

    logic [WORD_W-1:0]  op_a;
    logic [WORD_W-1:0]  rm_fwd;
    logic [WORD_W-1:0]  val2;
    logic [SHAMT_W-1:0] shamt;
    exe_mem_t           pipe_q, pipe_d;
    logic [FLAG_W-1:0]  status_q;

    always_comb begin
        case (sel_src_1)
            FWD_MEM: op_a = mem_fwd_val;
            FWD_WB:  op_a = wb_fwd_val;
            default: op_a = val_r_n_in;
        endcase
        case (sel_src_2)
            FWD_MEM: rm_fwd = mem_fwd_val;
            FWD_WB:  rm_fwd = wb_fwd_val;
            default: rm_fwd = val_r_m_in;
        endcase
    end

    assign shamt = shift_operand_in[SHIFT_W-1:SH_AMT_LSB];

    // Memory ops use the raw 12-bit offset, ahead of any immediate/shift decoding
    always_comb begin
        val2 = rm_fwd;
        if (mem_r_en_in || mem_w_en_in) begin
            val2 = WORD_W'(shift_operand_in);
        end else if (imm_in) begin
            val2 = ror_word(WORD_W'(shift_operand_in[IMM8_W-1:0]),
                            {shift_operand_in[SHIFT_W-1:IMM8_W], 1'b0});
        end else if (!shift_operand_in[SH_IMM_BIT]) begin
            case (shift_operand_in[SH_TYPE_LSB+1:SH_TYPE_LSB])
                SH_LSL:  val2 = rm_fwd << shamt;
                SH_LSR:  val2 = rm_fwd >> shamt;
                SH_ASR:  val2 = $signed(rm_fwd) >>> shamt;
                default: val2 = ror_word(rm_fwd, shamt);
            endcase
        end
    end

    exe_stage_module_if alu_bus ();

    assign alu_bus.op_a     = op_a;
    assign alu_bus.op_b     = val2;
    assign alu_bus.cmd      = exec_cmd_in;
    assign alu_bus.flags_in = status_q;

    exe_alu u_alu (
        .alu_if (alu_bus.slave)
    );

    always_comb begin
        pipe_d.wb_en      = wb_en_in;
        pipe_d.mem_r_en   = mem_r_en_in;
        pipe_d.mem_w_en   = mem_w_en_in;
        pipe_d.dest       = dest_in;
        pipe_d.alu_result = alu_bus.result;
        pipe_d.store_val  = rm_fwd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q   <= '0;
            status_q <= '0;
        end else if (!mem_freeze) begin
            pipe_q <= pipe_d;
            if (s_in) begin
                status_q <= alu_bus.flags_out;
            end
        end
    end

    assign wb_en_out    = pipe_q.wb_en;
    assign mem_r_en_out = pipe_q.mem_r_en;
    assign mem_w_en_out = pipe_q.mem_w_en;
    assign dest_out     = pipe_q.dest;
    assign alu_result   = pipe_q.alu_result;
    assign store_val    = pipe_q.store_val;
    assign status_reg   = status_q;

    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{(WORD_W-IMM24_W-BR_SHIFT){signed_imm_24_in[IMM24_W-1]}},
                                   signed_imm_24_in, {BR_SHIFT{1'b0}}};

endmodule
